// File: rtl/call_panel.sv
// rtl/call_panel.sv - elevator call capture, lamp keeping and one-shot request issue
//
// Purpose: synchronizes car/hall buttons and the penthouse key, latches accepted
// presses into lamps, and offers each pending call once over req_valid/req_ready.
// Calls at the current floor clear while doors are open; bigRedButton wipes all.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   car_btn, up_btn, down_btn      asynchronous button levels, one bit per floor
//   key                            asynchronous penthouse key switch
//   bigRedButton                   emergency stop, synchronous to clk
//   floor, open                    car position and door-open status
//   req_valid/req_kind/req_floor   request offer (kind 0 car, 1 up, 2 down)
//   req_ready                      controller accepts the offered request
//   car_lamp, up_lamp, down_lamp   pending-call lamps
module call_panel #(
  parameter int FLOORS      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] car_btn,
  input  logic [FLOORS-1:0] up_btn,
  input  logic [FLOORS-1:0] down_btn,
  input  logic              key,
  input  logic              bigRedButton,
  input  logic [2:0]        floor,
  input  logic              open,
  output logic              req_valid,
  output logic [1:0]        req_kind,
  output logic [2:0]        req_floor,
  input  logic              req_ready,
  output logic [FLOORS-1:0] car_lamp,
  output logic [FLOORS-1:0] up_lamp,
  output logic [FLOORS-1:0] down_lamp
);

  localparam int BW = 3 * FLOORS;  // button bits; key sits above them

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                           state, state_n;
  logic [SYNC_STAGES-1:0][BW:0]     sync_q;
  logic [BW-1:0]                    prev_q;
  logic [BW:0]                      sync_out;
  logic [BW-1:0]                    edges;
  logic                             key_s;
  logic [FLOORS-1:0]                car_acc, up_acc, down_acc, clr_mask;
  logic [FLOORS-1:0]                car_sent, up_sent, down_sent;
  logic [FLOORS-1:0]                car_sent_n, up_sent_n, down_sent_n;
  logic [FLOORS-1:0]                car_lamp_n, up_lamp_n, down_lamp_n;
  logic [FLOORS-1:0]                car_cand, up_cand, down_cand;
  logic [1:0]                       kind_n;
  logic [2:0]                       floor_n;
  logic                             hit, offer_clr;

  // Synchronizer chain plus registered copy for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {key, down_btn, up_btn, car_btn};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_out[BW-1:0];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edges    = sync_out[BW-1:0] & ~prev_q;
  assign key_s    = sync_out[BW];

  // Penthouse car call needs the key; top up-call and bottom down-call do not exist.
  always_comb begin
    car_acc  = edges[FLOORS-1:0];
    up_acc   = edges[2*FLOORS-1:FLOORS];
    down_acc = edges[BW-1:2*FLOORS];
    car_acc[FLOORS-1] = car_acc[FLOORS-1] & key_s;
    up_acc[FLOORS-1]  = 1'b0;
    down_acc[0]       = 1'b0;
  end

  // Service clear for the floor the doors are open at; out-of-range floors match nothing.
  always_comb begin
    clr_mask = '0;
    if (open)
      for (int i = 0; i < FLOORS; i++)
        if (floor == 3'(i)) clr_mask[i] = 1'b1;
  end

  // Calls being cleared this cycle are not eligible, so nothing stale is offered.
  assign car_cand  = car_lamp  & ~car_sent  & ~clr_mask;
  assign up_cand   = up_lamp   & ~up_sent   & ~clr_mask;
  assign down_cand = down_lamp & ~down_sent & ~clr_mask;

  always_comb begin
    state_n     = state;
    kind_n      = req_kind;
    floor_n     = req_floor;
    hit         = 1'b0;
    offer_clr   = 1'b0;
    car_sent_n  = car_sent;
    up_sent_n   = up_sent;
    down_sent_n = down_sent;
    // OR-ing an accepted press into a lit lamp is a no-op; clear wins over press.
    car_lamp_n  = (car_lamp  | car_acc)  & ~clr_mask;
    up_lamp_n   = (up_lamp   | up_acc)   & ~clr_mask;
    down_lamp_n = (down_lamp | down_acc) & ~clr_mask;

    case (state)
      IDLE: begin
        for (int i = 0; i < FLOORS; i++)
          if (!hit && car_cand[i]) begin hit = 1'b1; kind_n = 2'd0; floor_n = 3'(i); end
        for (int i = 0; i < FLOORS; i++)
          if (!hit && up_cand[i]) begin hit = 1'b1; kind_n = 2'd1; floor_n = 3'(i); end
        for (int i = 0; i < FLOORS; i++)
          if (!hit && down_cand[i]) begin hit = 1'b1; kind_n = 2'd2; floor_n = 3'(i); end
        if (hit) state_n = OFFER;
      end
      OFFER: begin
        for (int i = 0; i < FLOORS; i++)
          if (req_floor == 3'(i)) offer_clr = clr_mask[i];
        if (offer_clr) begin
          state_n = IDLE;  // withdraw: serviced before the controller took it
        end else if (req_ready) begin
          state_n = IDLE;
          for (int i = 0; i < FLOORS; i++)
            if (req_floor == 3'(i)) begin
              case (req_kind)
                2'd0:    car_sent_n[i]  = 1'b1;
                2'd1:    up_sent_n[i]   = 1'b1;
                default: down_sent_n[i] = 1'b1;
              endcase
            end
        end
      end
      default: state_n = IDLE;
    endcase

    car_sent_n  = car_sent_n  & ~clr_mask;
    up_sent_n   = up_sent_n   & ~clr_mask;
    down_sent_n = down_sent_n & ~clr_mask;

    if (bigRedButton) begin
      state_n     = IDLE;
      car_lamp_n  = '0;
      up_lamp_n   = '0;
      down_lamp_n = '0;
      car_sent_n  = '0;
      up_sent_n   = '0;
      down_sent_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_kind  <= '0;
      req_floor <= '0;
      car_lamp  <= '0;
      up_lamp   <= '0;
      down_lamp <= '0;
      car_sent  <= '0;
      up_sent   <= '0;
      down_sent <= '0;
    end else begin
      state     <= state_n;
      req_kind  <= kind_n;
      req_floor <= floor_n;
      car_lamp  <= car_lamp_n;
      up_lamp   <= up_lamp_n;
      down_lamp <= down_lamp_n;
      car_sent  <= car_sent_n;
      up_sent   <= up_sent_n;
      down_sent <= down_sent_n;
    end
  end

  assign req_valid = (state == OFFER);

endmodule

// File: tb/tb_call_panel.sv
// tb/tb_call_panel.sv - directed self-checking bench for call_panel
module tb_call_panel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] car_btn = '0, up_btn = '0, down_btn = '0;
  logic       key = 1'b0, bigRedButton = 1'b0, open = 1'b0, req_ready = 1'b0;
  logic [2:0] floor = '0;
  logic       req_valid;
  logic [1:0] req_kind;
  logic [2:0] req_floor;
  logic [4:0] car_lamp, up_lamp, down_lamp;

  int checks = 0;
  int failures = 0;

  call_panel #(.FLOORS(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .car_btn(car_btn), .up_btn(up_btn), .down_btn(down_btn),
    .key(key), .bigRedButton(bigRedButton),
    .floor(floor), .open(open),
    .req_valid(req_valid), .req_kind(req_kind), .req_floor(req_floor),
    .req_ready(req_ready),
    .car_lamp(car_lamp), .up_lamp(up_lamp), .down_lamp(down_lamp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // {valid, kind, floor}
  function automatic logic [5:0] req();
    return {req_valid, req_kind, req_floor};
  endfunction

  function automatic logic [14:0] lamps();
    return {down_lamp, up_lamp, car_lamp};
  endfunction

  logic stable;

  initial begin
    // Reset
    tick(2);
    check("reset_req", 32'(req()), 32'h0);
    check("reset_lamps", 32'(lamps()), 32'h0);
    rst = 1'b0;
    tick(1);

    // Single car call, latency and stall
    car_btn = 5'b00100;
    tick(2);
    check("car2_lamp_e1", 32'(car_lamp), 32'h0);
    tick(1);
    check("car2_lamp_e2", 32'(car_lamp), 32'b00100);
    check("car2_valid_e2", 32'(req_valid), 32'h0);
    tick(1);
    check("car2_offer", 32'(req()), {26'd0, 1'b1, 2'd0, 3'd2});
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (req() != {1'b1, 2'd0, 3'd2}) stable = 1'b0;
    end
    check("car2_stall_stable", 32'(stable), 32'h1);
    req_ready = 1'b1;
    tick(1);
    check("car2_after_xfer", 32'(req_valid), 32'h0);
    tick(4);
    check("car2_no_reissue", 32'(req_valid), 32'h0);
    check("car2_lamp_held", 32'(car_lamp), 32'b00100);
    car_btn = '0;
    floor = 3'd2; open = 1'b1;
    tick(1);
    check("car2_serviced", 32'(car_lamp), 32'h0);
    open = 1'b0;
    tick(3);

    // Priority order with ready high
    car_btn = 5'b01000; up_btn = 5'b00010; down_btn = 5'b00010;
    tick(3);
    check("prio_lamps", 32'(lamps()), {17'd0, 5'b00010, 5'b00010, 5'b01000});
    tick(1);
    check("prio_1st", 32'(req()), {26'd0, 1'b1, 2'd0, 3'd3});
    tick(1);
    check("prio_gap1", 32'(req_valid), 32'h0);
    tick(1);
    check("prio_2nd", 32'(req()), {26'd0, 1'b1, 2'd1, 3'd1});
    tick(1);
    check("prio_gap2", 32'(req_valid), 32'h0);
    tick(1);
    check("prio_3rd", 32'(req()), {26'd0, 1'b1, 2'd2, 3'd1});
    tick(3);
    check("prio_done", 32'(req_valid), 32'h0);
    car_btn = '0; up_btn = '0; down_btn = '0;
    open = 1'b1; floor = 3'd3;
    tick(1);
    floor = 3'd1;
    tick(1);
    open = 1'b0;
    check("prio_cleared", 32'(lamps()), 32'h0);
    tick(3);

    // Penthouse key rule and nonexistent hall buttons
    req_ready = 1'b0;
    car_btn = 5'b10000;
    tick(5);
    check("pent_nokey_lamp", 32'(car_lamp), 32'h0);
    check("pent_nokey_valid", 32'(req_valid), 32'h0);
    car_btn = '0; key = 1'b1;
    tick(3);
    car_btn = 5'b10000;
    tick(3);
    check("pent_key_lamp", 32'(car_lamp), 32'b10000);
    tick(1);
    check("pent_key_offer", 32'(req()), {26'd0, 1'b1, 2'd0, 3'd4});
    req_ready = 1'b1;
    tick(1);
    check("pent_xfer", 32'(req_valid), 32'h0);
    car_btn = '0; key = 1'b0;
    up_btn = 5'b10000; down_btn = 5'b00001;
    tick(5);
    check("edge_btns_lamps", 32'({down_lamp, up_lamp}), 32'h0);
    check("edge_btns_valid", 32'(req_valid), 32'h0);
    up_btn = '0; down_btn = '0;
    floor = 3'd7; open = 1'b1;
    tick(1);
    check("floor7_ignored", 32'(car_lamp), 32'b10000);
    floor = 3'd4;
    tick(1);
    check("floor4_clear", 32'(car_lamp), 32'h0);
    open = 1'b0;
    tick(2);

    // Withdraw on service before acceptance
    req_ready = 1'b0;
    up_btn = 5'b00100;
    tick(4);
    check("wd_offer", 32'(req()), {26'd0, 1'b1, 2'd1, 3'd2});
    up_btn = '0;
    floor = 3'd2; open = 1'b1;
    tick(1);
    check("wd_valid_drop", 32'(req_valid), 32'h0);
    check("wd_lamp_clear", 32'(up_lamp), 32'h0);
    open = 1'b0; req_ready = 1'b1;
    tick(4);
    check("wd_no_reissue", 32'(req_valid), 32'h0);

    // Emergency stop
    req_ready = 1'b0;
    car_btn = 5'b00010; up_btn = 5'b01000; down_btn = 5'b10000;
    tick(4);
    check("emg_pre_offer", 32'(req()), {26'd0, 1'b1, 2'd0, 3'd1});
    check("emg_pre_lamps", 32'(lamps()), {17'd0, 5'b10000, 5'b01000, 5'b00010});
    car_btn = '0; up_btn = '0; down_btn = '0;
    bigRedButton = 1'b1;
    tick(1);
    check("emg_lamps", 32'(lamps()), 32'h0);
    check("emg_valid", 32'(req_valid), 32'h0);
    car_btn = 5'b00001;
    tick(5);
    check("emg_press_lamps", 32'(lamps()), 32'h0);
    check("emg_press_valid", 32'(req_valid), 32'h0);
    car_btn = '0;
    tick(3);
    bigRedButton = 1'b0;
    tick(3);
    check("emg_release_quiet", 32'({req_valid, lamps()}), 32'h0);
    car_btn = 5'b00001;
    tick(3);
    check("emg_new_lamp", 32'(car_lamp), 32'b00001);
    tick(1);
    check("emg_new_offer", 32'(req()), {26'd0, 1'b1, 2'd0, 3'd0});
    car_btn = '0;

    // Asynchronous reset mid-offer
    #3;
    rst = 1'b1;
    #1;
    check("arst_req", 32'(req()), 32'h0);
    check("arst_lamps", 32'(lamps()), 32'h0);
    tick(2);
    #2;
    rst = 1'b0;
    tick(4);
    check("arst_after_req", 32'(req_valid), 32'h0);
    check("arst_after_lamps", 32'(lamps()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
